// File: rtl/red_operand_packer.sv
// red_operand_packer: serial byte front end for the RED datapath.
// Packs every four accepted bytes into an A/B operand pair using the lane order
// the reduction consumes. Completed pairs wait in a small output FIFO.
// A flush closes a partial group. Its missing lanes are zero-padded, and the
// FIFO entry is marked partial.
module red_operand_packer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [15:0]      out_A,
  output logic [15:0]      out_B,
  output logic             out_partial,
  input  logic             out_ready,
  output logic [CNT_W:0]   fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0] FULL_CNT = (CNT_W+1)'(DEPTH);

  // Assembly state
  logic [1:0]       lane_q, lane_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic             flush_pend_q, flush_pend_d;

  // FIFO state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W:0]   count_q, count_d;
  logic [15:0]      mem_a_q [DEPTH];
  logic [15:0]      mem_b_q [DEPTH];
  logic             mem_p_q [DEPTH];

  logic             fifo_full;
  logic             accept;
  logic             pop;
  logic             push;
  logic             push_p;
  logic [15:0]      merge_a, merge_b;

  assign fifo_full = (count_q == FULL_CNT);
  // The lane-3 byte needs a free FIFO slot. A pending flush blocks new bytes
  // until the padded group has been pushed.
  assign in_ready  = !flush_pend_q && ((lane_q != 2'd3) || !fifo_full);
  assign accept    = in_valid && in_ready;
  assign pop       = (count_q != '0) && out_ready;

  // Merge the byte accepted this cycle into the assembly at its lane position
  always_comb begin
    merge_a = a_q;
    merge_b = b_q;
    if (accept) begin
      case (lane_q)
        2'd0:    merge_a[7:0]  = in_byte;
        2'd1:    merge_b[7:0]  = in_byte;
        2'd2:    merge_a[15:8] = in_byte;
        default: merge_b[15:8] = in_byte;
      endcase
    end
  end

  // Next-state logic for the lane, assembly and flush, and FIFO push decision
  always_comb begin
    lane_d       = lane_q;
    a_d          = a_q;
    b_d          = b_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_p       = 1'b0;
    if (flush_pend_q) begin
      // in_ready is low here, so no new byte can arrive; wait for space
      if (!fifo_full) begin
        push         = 1'b1;
        push_p       = 1'b1;
        a_d          = '0;
        b_d          = '0;
        lane_d       = 2'd0;
        flush_pend_d = 1'b0;
      end
    end else if (accept && (lane_q == 2'd3)) begin
      // A full group commits normally and absorbs any coincident flush
      push   = 1'b1;
      a_d    = '0;
      b_d    = '0;
      lane_d = 2'd0;
    end else if (flush && (accept || (lane_q != 2'd0))) begin
      if (!fifo_full) begin
        push   = 1'b1;
        push_p = 1'b1;
        a_d    = '0;
        b_d    = '0;
        lane_d = 2'd0;
      end else begin
        a_d          = merge_a;
        b_d          = merge_b;
        lane_d       = accept ? lane_q + 2'd1 : lane_q;
        flush_pend_d = 1'b1;
      end
    end else if (accept) begin
      a_d    = merge_a;
      b_d    = merge_b;
      lane_d = lane_q + 2'd1;
    end
  end

  // FIFO pointer and occupancy next-state; push+pop together keeps the count
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
  end

  // Control and assembly registers with async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= 2'd0;
      a_q          <= '0;
      b_q          <= '0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      lane_q       <= lane_d;
      a_q          <= a_d;
      b_q          <= b_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage. It has no reset because the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= push_p ? merge_a : merge_a;
      mem_b_q[wr_ptr_q] <= merge_b;
      mem_p_q[wr_ptr_q] <= push_p;
    end
  end

  assign out_valid   = (count_q != '0);
  assign out_A       = out_valid ? mem_a_q[rd_ptr_q] : 16'h0000;
  assign out_B       = out_valid ? mem_b_q[rd_ptr_q] : 16'h0000;
  assign out_partial = out_valid ? mem_p_q[rd_ptr_q] : 1'b0;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_red_operand_packer.sv
// Directed testbench for red_operand_packer. Expected values are hand-computed.
module tb_red_operand_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_A;
  logic [15:0] out_B;
  logic        out_partial;
  logic        out_ready;
  logic [2:0]  fifo_count;

  int tests_run = 0;
  int tests_failed = 0;

  red_operand_packer #(.DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_A(out_A),
    .out_B(out_B), .out_partial(out_partial), .out_ready(out_ready),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until it is accepted, with a bounded wait
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic p);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_A"}, {16'd0, out_A}, {16'd0, a});
    check({tag, "_B"}, {16'd0, out_B}, {16'd0, b});
    check({tag, "_partial"}, {31'd0, out_partial}, {31'd0, p});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_A", {16'd0, out_A}, 32'd0);
    check("rst_B", {16'd0, out_B}, 32'd0);
    check("rst_partial", {31'd0, out_partial}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Basic pack, out_valid the cycle after the 4th accept, then pop
    out_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check_head("basic", 16'h3311, 16'h4422, 1'b0);
    check("basic_count", {29'd0, fifo_count}, 32'd1);
    step();
    check("basic_popped", {29'd0, fifo_count}, 32'd0);
    check("basic_empty_A", {16'd0, out_A}, 32'd0);
    $display("[TB] basic pack 11,22,33,44 done");

    // Backpressure: fill the FIFO and stall the 12th byte
    out_ready = 1'b0;
    for (int i = 1; i <= 11; i++) send(8'(i));
    check("bp_count_full", {29'd0, fifo_count}, 32'd2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check_head("bp_head0", 16'h0301, 16'h0402, 1'b0);
    in_byte = 8'h0C; in_valid = 1'b1;
    step(); step();
    check("bp_still_stalled", {31'd0, in_ready}, 32'd0);
    check("bp_count_held", {29'd0, fifo_count}, 32'd2);
    out_ready = 1'b1;
    step();
    check("bp_after_pop_count", {29'd0, fifo_count}, 32'd1);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    check_head("bp_head1", 16'h0705, 16'h0806, 1'b0);
    step();
    in_valid = 1'b0;
    check("bp_pushpop_count", {29'd0, fifo_count}, 32'd1);
    check_head("bp_head2", 16'h0B09, 16'h0C0A, 1'b0);
    step();
    check("bp_drained", {29'd0, fifo_count}, 32'd0);
    out_ready = 1'b0;
    $display("[TB] backpressure 12 bytes done");

    // Flush of a two-byte group, then a flush with no group open
    send(8'hAA); send(8'hBB);
    flush = 1'b1; step(); flush = 1'b0;
    check("fl_count", {29'd0, fifo_count}, 32'd1);
    check_head("fl_head", 16'h00AA, 16'h00BB, 1'b1);
    flush = 1'b1; step(); flush = 1'b0;
    check("fl_noop_count", {29'd0, fifo_count}, 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("fl_popped", {29'd0, fifo_count}, 32'd0);
    $display("[TB] flush of AA,BB done");

    // Flush coincident with the 3rd byte
    send(8'h01); send(8'h02);
    in_byte = 8'hCC; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("fl3_count", {29'd0, fifo_count}, 32'd1);
    check_head("fl3_head", 16'hCC01, 16'h0002, 1'b1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Flush coincident with the 4th byte is absorbed by the normal commit
    send(8'h05); send(8'h06); send(8'h07);
    in_byte = 8'h08; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check_head("fl4_head", 16'h0705, 16'h0806, 1'b0);
    step();
    check("fl4_single_entry", {29'd0, fifo_count}, 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("fl4_popped", {29'd0, fifo_count}, 32'd0);
    $display("[TB] flush with 3rd/4th byte done");

    // Flush while the FIFO is full goes pending until a slot frees up
    for (int i = 0; i < 8; i++) send(8'(8'h21 + i));
    send(8'h5A);
    check("fp_in_ready_lane1", {31'd0, in_ready}, 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    check("fp_pend_in_ready", {31'd0, in_ready}, 32'd0);
    check("fp_count_full", {29'd0, fifo_count}, 32'd2);
    step();
    check("fp_pend_hold", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("fp_pop_count", {29'd0, fifo_count}, 32'd1);
    check("fp_pop_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("fp_push_count", {29'd0, fifo_count}, 32'd2);
    check("fp_in_ready_back", {31'd0, in_ready}, 32'd1);
    check_head("fp_head1", 16'h2725, 16'h2826, 1'b0);
    out_ready = 1'b1; step();
    check_head("fp_head_pad", 16'h005A, 16'h0000, 1'b1);
    step(); out_ready = 1'b0;
    check("fp_drained", {29'd0, fifo_count}, 32'd0);
    $display("[TB] flush pending on full FIFO done");

    // Asynchronous reset with one entry queued and two bytes assembled
    for (int i = 0; i < 6; i++) send(8'(8'h61 + i));
    check("ar_pre_count", {29'd0, fifo_count}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_A", {16'd0, out_A}, 32'd0);
    check("ar_B", {16'd0, out_B}, 32'd0);
    check("ar_count", {29'd0, fifo_count}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    #3;
    rst_n = 1'b1;
    step();
    send(8'h10); send(8'h11); send(8'h12); send(8'h13);
    check("ar_post_count", {29'd0, fifo_count}, 32'd1);
    check_head("ar_post_head", 16'h1210, 16'h1311, 1'b0);
    $display("[TB] async reset mid-group done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
